// File: rtl/draw_pkg.sv
// Shared types and defaults for the Bresenham line engine.
package draw_pkg;

    localparam int CORDW_DEF = 16;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        INIT = 2'd1,
        DRAW = 2'd2
    } state_e;

endpackage

// File: rtl/draw_line.sv
// Bresenham line engine: walks from the lower-y endpoint to the other, one pixel per oe cycle.
// Optional clip gating of `drawing` with DRAW_LINE_CLIP_EN.
module draw_line
    import draw_pkg::*;
#(
    parameter int CORDW = CORDW_DEF,
    parameter int CLIPW = 320,
    parameter int CLIPH = 180
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    start,
    input  logic                    oe,
    input  logic signed [CORDW-1:0] x0,
    input  logic signed [CORDW-1:0] y0,
    input  logic signed [CORDW-1:0] x1,
    input  logic signed [CORDW-1:0] y1,
    output logic signed [CORDW-1:0] x,
    output logic signed [CORDW-1:0] y,
    output logic                    drawing,
    output logic                    busy,
    output logic                    done
);

    state_e state_q, state_d;

    logic signed [CORDW-1:0] xa_q, xa_d, ya_q, ya_d;
    logic signed [CORDW-1:0] xb_q, xb_d, yb_q, yb_d;
    logic                    xneg_q, xneg_d;
    logic signed [CORDW:0]   dx_q, dx_d, dy_q, dy_d;
    logic signed [CORDW+1:0] err_q, err_d;
    logic signed [CORDW-1:0] x_q, x_d, y_q, y_d;
    logic                    done_q, done_d;

    // Endpoint ordering so y only ever increments
    logic                    swap;
    logic signed [CORDW-1:0] xa_in, ya_in, xb_in, yb_in;

    assign swap  = (y0 > y1);
    assign xa_in = swap ? x1 : x0;
    assign ya_in = swap ? y1 : y0;
    assign xb_in = swap ? x0 : x1;
    assign yb_in = swap ? y0 : y1;

    logic signed [CORDW:0]   xa_ext, xb_ext, ya_ext, yb_ext;
    logic signed [CORDW:0]   dx_init, dy_init;
    logic signed [CORDW+1:0] err_init;

    assign xa_ext   = {xa_q[CORDW-1], xa_q};
    assign xb_ext   = {xb_q[CORDW-1], xb_q};
    assign ya_ext   = {ya_q[CORDW-1], ya_q};
    assign yb_ext   = {yb_q[CORDW-1], yb_q};
    assign dx_init  = xneg_q ? (xa_ext - xb_ext) : (xb_ext - xa_ext);
    assign dy_init  = ya_ext - yb_ext;
    assign err_init = {dx_init[CORDW], dx_init} + {dy_init[CORDW], dy_init};

    localparam logic signed [CORDW+1:0] ERR_ZERO = '0;

    logic signed [CORDW+2:0] e2, dx_e2, dy_e2;
    logic signed [CORDW+1:0] dx_w, dy_w, err_step;
    logic signed [CORDW-1:0] x_inc;
    logic                    step_x, step_y, at_end;

    assign e2       = {err_q, 1'b0};
    assign dx_e2    = {{2{dx_q[CORDW]}}, dx_q};
    assign dy_e2    = {{2{dy_q[CORDW]}}, dy_q};
    assign dx_w     = {dx_q[CORDW], dx_q};
    assign dy_w     = {dy_q[CORDW], dy_q};
    assign step_x   = (e2 >= dy_e2);
    assign step_y   = (e2 <= dx_e2);
    assign err_step = err_q + (step_x ? dy_w : ERR_ZERO) + (step_y ? dx_w : ERR_ZERO);
    assign x_inc    = xneg_q ? {CORDW{1'b1}} : CORDW'(1);
    assign at_end   = (x_q == xb_q) && (y_q == yb_q);

    always_comb begin
        state_d = state_q;
        xa_d    = xa_q;
        ya_d    = ya_q;
        xb_d    = xb_q;
        yb_d    = yb_q;
        xneg_d  = xneg_q;
        dx_d    = dx_q;
        dy_d    = dy_q;
        err_d   = err_q;
        x_d     = x_q;
        y_d     = y_q;
        done_d  = 1'b0;
        case (state_q)
            IDLE: begin
                if (start) begin
                    xa_d    = xa_in;
                    ya_d    = ya_in;
                    xb_d    = xb_in;
                    yb_d    = yb_in;
                    xneg_d  = (xa_in > xb_in);
                    state_d = INIT;
                end
            end
            INIT: begin
                dx_d    = dx_init;
                dy_d    = dy_init;
                err_d   = err_init;
                x_d     = xa_q;
                y_d     = ya_q;
                state_d = DRAW;
            end
            DRAW: begin
                if (oe) begin
                    if (at_end) begin
                        state_d = IDLE;
                        done_d  = 1'b1;
                    end else begin
                        err_d = err_step;
                        if (step_x) x_d = x_q + x_inc;
                        if (step_y) y_d = y_q + CORDW'(1);
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            xa_q    <= '0;
            ya_q    <= '0;
            xb_q    <= '0;
            yb_q    <= '0;
            xneg_q  <= 1'b0;
            dx_q    <= '0;
            dy_q    <= '0;
            err_q   <= '0;
            x_q     <= '0;
            y_q     <= '0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            xa_q    <= xa_d;
            ya_q    <= ya_d;
            xb_q    <= xb_d;
            yb_q    <= yb_d;
            xneg_q  <= xneg_d;
            dx_q    <= dx_d;
            dy_q    <= dy_d;
            err_q   <= err_d;
            x_q     <= x_d;
            y_q     <= y_d;
            done_q  <= done_d;
        end
    end

    logic in_clip;

`ifdef DRAW_LINE_CLIP_EN
    localparam logic [CORDW:0] CLIPW_C = (CORDW+1)'(CLIPW);
    localparam logic [CORDW:0] CLIPH_C = (CORDW+1)'(CLIPH);

    // Clipped pixels still consume their oe cycle; only the strobe is masked
    assign in_clip = !x_q[CORDW-1] && !y_q[CORDW-1] &&
                     ({1'b0, x_q} < CLIPW_C) && ({1'b0, y_q} < CLIPH_C);
`else
    logic unused_clip;
    assign unused_clip = ^{CLIPW, CLIPH};
    assign in_clip     = 1'b1;
`endif

    assign drawing = (state_q == DRAW) && oe && in_clip;
    assign busy    = (state_q != IDLE);
    assign done    = done_q;
    assign x       = x_q;
    assign y       = y_q;

endmodule
